// File: rtl/axi3_scratch_device.sv
// AXI3 slave scratch memory: independent read/write FSMs, strobe-merged store, identity data for unwritten words.
// Optional random back-pressure on rvalid/wready when AXI_SLAVE_RAND_STALL_EN is defined.
module axi3_scratch_device #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LATENCY = 2,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              rd_state_dbg,
    output logic [1:0]              wr_state_dbg,
    output logic                    proto_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [3:0] len,
                                                        input logic [1:0] burst,
                                                        input logic [3:0] n);
        logic [ADDR_WIDTH-1:0] aligned, step, wrap_mask;
        aligned   = base & ~LOW_MASK;
        step      = ADDR_WIDTH'(n) * ADDR_WIDTH'(BYTES);
        wrap_mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: beat_addr = base;
            BURST_WRAP:  beat_addr = (aligned & ~wrap_mask) | ((aligned + step) & wrap_mask);
            default:     beat_addr = aligned + step;
        endcase
    endfunction

    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
        bad_req = (size != 3'(LB)) || (burst == 2'b11) ||
                  ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    logic [1:0]            r_state_q, r_state_d, w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d, bid_q, bid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [3:0]            rlen_q, rlen_d, wlen_q, wlen_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic [1:0]            rburst_q, rburst_d, wburst_q, wburst_d;
    logic [LAT_W-1:0]      wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [MEM_DEPTH-1:0]  valid_q, valid_d;
    logic                  proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  stall, r_hs, w_hs, w_at_len, rd_load, mem_we, unused_w_addr;
    logic [ADDR_WIDTH-1:0] rd_src_addr, w_beat_addr;
    logic [IW-1:0]         rd_idx, w_idx;
    logic [DATA_WIDTH-1:0] rd_word, w_old, w_merged;

`ifdef AXI_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = (lfsr_q[1:0] == 2'b00);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign arready      = (r_state_q == R_IDLE);
    assign rvalid       = (r_state_q == R_BURST) && !stall;
    assign rlast        = (r_state_q == R_BURST) && (rcnt_q == rlen_q);
    assign rid          = rid_q;
    assign rdata        = rdata_q;
    assign rresp        = 2'b00;
    assign awready      = (w_state_q == W_IDLE);
    assign wready       = (w_state_q == W_DATA) && !stall;
    assign bvalid       = (w_state_q == W_RESP);
    assign bid          = bid_q;
    assign bresp        = 2'b00;
    assign proto_err    = proto_err_q;
    assign rd_state_dbg = r_state_q;
    assign wr_state_dbg = w_state_q;
    assign r_hs         = rvalid && rready;
    assign w_hs         = wvalid && wready;
    assign w_at_len     = (wcnt_q == wlen_q);

    // rdata is registered one cycle ahead of its beat, so it cannot move while rready is low.
    always_comb begin
        rd_load     = 1'b0;
        rd_src_addr = '0;
        case (r_state_q)
            R_IDLE: if (arvalid && RD_LATENCY == 0) begin
                rd_load     = 1'b1;
                rd_src_addr = beat_addr(araddr, arlen, arburst, 4'd0);
            end
            R_WAIT: if (wait_q == LAT_W'(RD_LATENCY - 1)) begin
                rd_load     = 1'b1;
                rd_src_addr = beat_addr(raddr_q, rlen_q, rburst_q, 4'd0);
            end
            R_BURST: if (r_hs && !rlast) begin
                rd_load     = 1'b1;
                rd_src_addr = beat_addr(raddr_q, rlen_q, rburst_q, rcnt_q + 4'd1);
            end
            default: ;
        endcase
    end

    assign rd_idx  = rd_src_addr[LB +: IW];
    assign rd_word = valid_q[rd_idx] ? mem_q[rd_idx] : DATA_WIDTH'(rd_src_addr & ~LOW_MASK);

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        wait_d    = wait_q;
        rdata_d   = rd_load ? rd_word : rdata_q;
        case (r_state_q)
            R_IDLE: if (arvalid) begin
                rid_d     = arid;
                raddr_d   = araddr;
                rlen_d    = arlen;
                rburst_d  = arburst;
                rcnt_d    = 4'd0;
                wait_d    = '0;
                r_state_d = (RD_LATENCY == 0) ? R_BURST : R_WAIT;
            end
            R_WAIT: begin
                wait_d = wait_q + LAT_W'(1);
                if (wait_q == LAT_W'(RD_LATENCY - 1)) r_state_d = R_BURST;
            end
            R_BURST: if (r_hs) begin
                if (rlast) begin
                    r_state_d = R_IDLE;
                    rcnt_d    = 4'd0;
                    rdata_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // A word that was never written contributes zeros for its unstrobed bytes.
    assign w_beat_addr   = beat_addr(waddr_q, wlen_q, wburst_q, wcnt_q);
    assign w_idx         = w_beat_addr[LB +: IW];
    assign w_old         = valid_q[w_idx] ? mem_q[w_idx] : '0;
    assign unused_w_addr = ^w_beat_addr;

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < BYTES; b++)
            if (wstrb[b]) w_merged[8*b +: 8] = wdata[8*b +: 8];
    end

    always_comb begin
        w_state_d   = w_state_q;
        bid_d       = bid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wburst_d    = wburst_q;
        wcnt_d      = wcnt_q;
        valid_d     = valid_q;
        mem_we      = 1'b0;
        proto_err_d = proto_err_q;
        if (arvalid && arready && bad_req(arsize, arburst, arlen)) proto_err_d = 1'b1;
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                bid_d     = awid;
                waddr_d   = awaddr;
                wlen_d    = awlen;
                wburst_d  = awburst;
                wcnt_d    = 4'd0;
                w_state_d = W_DATA;
                if (bad_req(awsize, awburst, awlen)) proto_err_d = 1'b1;
            end
            W_DATA: if (w_hs) begin
                mem_we         = 1'b1;
                valid_d[w_idx] = 1'b1;
                if (wlast != w_at_len) proto_err_d = 1'b1;
                if (wlast || w_at_len) begin
                    w_state_d = W_RESP;
                    wcnt_d    = 4'd0;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[w_idx] <= w_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            rid_q       <= '0;
            bid_q       <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            rlen_q      <= '0;
            wlen_q      <= '0;
            rburst_q    <= '0;
            wburst_q    <= '0;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            valid_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            rid_q       <= rid_d;
            bid_q       <= bid_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            rlen_q      <= rlen_d;
            wlen_q      <= wlen_d;
            rburst_q    <= rburst_d;
            wburst_q    <= wburst_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_axi3_scratch_device.sv
// Bench for axi3_scratch_device: table of read bursts plus hand-written write, overlap, error and reset sequences.
module tb_axi3_scratch_device;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp, rd_state_dbg, wr_state_dbg;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, proto_err;

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [1:0]       burst;
        logic [2:0]       size;
        logic [3:0]       id;
        logic [3:0][31:0] d;
        logic             perr;
    } rd_vec_t;

    rd_vec_t     vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] wd_a[16];
    logic [3:0]  ws_a[16];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    axi3_scratch_device #(.RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg), .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic add_vec(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                           input logic perr);
        rd_vec_t v;
        v.addr = addr; v.len = len; v.burst = burst; v.size = size; v.id = id;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.perr = perr;
        vecs.push_back(v);
    endtask

    // Expected beats come from exp_q, pushed by the caller before the burst starts.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int max_gap);
        int g, n, gaps;
        logic [31:0] hold_d;
        logic hold_l;
        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 100) begin step(); g++; end
        chk("ar_ready", arready, 1);
        step();
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 100) begin step(); n++; end
        chk("r_first_latency", n, 1 + RD_LAT);
        for (int b = 0; b <= int'(len); b++) begin
            g = 0;
            while (!rvalid && g < 100) begin step(); g++; end
            chk("r_valid", rvalid, 1);
            gaps = $urandom_range(0, max_gap);
            hold_d = rdata;
            hold_l = rlast;
            rready = 1'b0;
            for (int k = 0; k < gaps; k++) begin
                step();
                chk("r_hold_data", rdata, hold_d);
                chk("r_hold_last", rlast, hold_l);
            end
            rready = 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL r_data actual=%h required=<none queued>", rdata);
            end else begin
                chk("r_data", rdata, exp_q.pop_front());
            end
            chk("r_last", rlast, (b == int'(len)));
            chk("r_id", rid, id);
            chk("r_resp", rresp, 2'b00);
            step();
            rready = 1'b0;
        end
        chk("ar_ready_after_last", arready, 1);
        chk("r_valid_after_last", rvalid, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input int nbeats, input int pre_gap);
        int g;
        awaddr = addr; awlen = len; awid = id; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 100) begin step(); g++; end
        chk("aw_ready", awready, 1);
        step();
        awvalid = 1'b0;
        chk("w_ready_after_aw", wready, 1);
        for (int k = 0; k < pre_gap; k++) step();
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd_a[b]; wstrb = ws_a[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
            g = 0;
            while (!wready && g < 100) begin step(); g++; end
            chk("w_ready", wready, 1);
            step();
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        chk("b_valid", bvalid, 1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, 2'b00);
        step();
        chk("b_held", bvalid, 1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("aw_ready_after_b", awready, 1);
        chk("b_valid_after_b", bvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        add_vec(32'h100, 4'd3, 2'b01, 3'd2, 4'd1, 32'h100, 32'h104, 32'h108, 32'h10C, 1'b0);
        add_vec(32'h018, 4'd3, 2'b10, 3'd2, 4'd2, 32'h018, 32'h01C, 32'h010, 32'h014, 1'b0);
        add_vec(32'h023, 4'd1, 2'b00, 3'd2, 4'd3, 32'h020, 32'h020, 32'h0, 32'h0, 1'b0);
        add_vec(32'h03C, 4'd1, 2'b10, 3'd2, 4'd4, 32'h03C, 32'h038, 32'h0, 32'h0, 1'b0);
        add_vec(32'h1FC, 4'd1, 2'b01, 3'd2, 4'd6, 32'h1FC, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0);
        add_vec(32'h440, 4'd0, 2'b01, 3'd2, 4'hA, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0);
        add_vec(32'h050, 4'd1, 2'b11, 3'd2, 4'hB, 32'h050, 32'h054, 32'h0, 32'h0, 1'b1);
        add_vec(32'h060, 4'd0, 2'b01, 3'd1, 4'hC, 32'h060, 32'h0, 32'h0, 32'h0, 1'b1);

        apply_reset();
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rd_state", rd_state_dbg, 0);
        chk("rst_wr_state", wr_state_dbg, 0);

        wd_a[0] = 32'hDEADBEEF; ws_a[0] = 4'hF;
        wd_a[1] = 32'h12345678; ws_a[1] = 4'h3;
        do_write(32'h40, 4'd1, 4'd5, 2, 0);
        chk("perr_after_write", proto_err, 0);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h00005678);
        do_read(32'h40, 4'd1, 2'b01, 3'd2, 4'd1, 2);

        // Write beat lands on the same edge as the read beat of the same word.
        wd_a[0] = 32'hCAFEF00D; ws_a[0] = 4'hF;
        exp_q.push_back(32'h200);
        fork
            do_read(32'h200, 4'd0, 2'b01, 3'd2, 4'd8, 0);
            do_write(32'h200, 4'd0, 4'd9, 1, RD_LAT);
        join
        exp_q.push_back(32'hCAFEF00D);
        do_read(32'h200, 4'd0, 2'b01, 3'd2, 4'd8, 2);

        foreach (vecs[i]) begin
            for (int b = 0; b <= int'(vecs[i].len); b++) exp_q.push_back(vecs[i].d[b]);
            do_read(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size, vecs[i].id, 2);
            chk("vec_proto_err", proto_err, vecs[i].perr);
        end

        apply_reset();
        chk("perr_cleared_by_rst", proto_err, 0);
        wd_a[0] = 32'h11111111; ws_a[0] = 4'hF;
        wd_a[1] = 32'h22222222; ws_a[1] = 4'hF;
        do_write(32'h300, 4'd3, 4'd7, 2, 0);
        chk("perr_early_wlast", proto_err, 1);
        chk("wr_state_idle_after_b", wr_state_dbg, 0);
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h308);
        do_read(32'h300, 4'd2, 2'b01, 3'd2, 4'd2, 1);

        araddr = 32'h100; arlen = 4'd3; arburst = 2'b01; arsize = 3'd2; arid = 4'd3; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int g = 0; g < 100 && !rvalid; g++) step();
        rready = 1'b1;
        step();
        step();
        chk("mid_beat2_data", rdata, 32'h108);
        chk("mid_beat2_valid", rvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_rlast", rlast, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        rready = 1'b0;
        step();
        rst = 1'b0;
        step();
        exp_q.push_back(32'h300);
        do_read(32'h300, 4'd0, 2'b01, 3'd2, 4'd4, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi3_scratch_device.md
# axi3_scratch_device

AXI3 slave memory model for testbenches. Reads and writes are served by independent FSMs. Reads return stored data for written words and the identity pattern (byte address) for unwritten words. Writes are merged under byte strobes into a MEM_DEPTH-word array. It is the parametrised successor of the identity-pattern test slave and adds configurable read latency, FIXED/INCR/WRAP bursts, ID echo, held B responses and protocol-error detection; it sits behind cache/uncached AXI masters in unit benches.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; BYTES = DATA_WIDTH/8, power of two
- MEM_DEPTH, 256, words of backing store; power of two
- RD_LATENCY, 2, idle cycles from AR handshake to first rvalid; 0 allowed
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- axi3_rd_if  slave  —  AR channel: arid, araddr, arlen[3:0], arsize, arburst, arvalid, arready. R channel: rid, rdata, rresp, rlast, rvalid, rready
- axi3_wr_if  slave  —  AW channel: awid, awaddr, awlen, awsize, awburst, awvalid, awready. W channel: wdata, wstrb, wlast, wvalid, wready. B channel: bid, bresp, bvalid, bready
- proto_err  out  1  sticky protocol-error flag; cleared only by rst

## Operation
- Word index = addr[$clog2(BYTES) +: $clog2(MEM_DEPTH)]; higher address bits are ignored (aliasing).
- Each word has a valid bit. Reset clears all valid bits; contents are don't-care.
- Read data per beat = mem[idx] if valid, else the beat byte address with low $clog2(BYTES) bits cleared, zero-extended or truncated to DATA_WIDTH.
- Beat address n:
  - FIXED (00): base.
  - INCR (01): aligned base + n*BYTES.
  - WRAP (10): aligned base, with the low bits inside a (len+1)*BYTES boundary wrapping.
  - burst 11 is treated as INCR and sets proto_err.
- Size checks: arsize/awsize ≠ $clog2(BYTES) sets proto_err; the transfer still runs at full width. WRAP with len ∉ {1,3,7,15} sets proto_err.
- Read FSM R_IDLE → R_WAIT → R_BURST → R_IDLE:
  - arready = (state == R_IDLE).
  - On the AR handshake, latch id/addr/len/burst and clear the beat counter. Enter R_WAIT for RD_LATENCY cycles, or go straight to R_BURST if RD_LATENCY = 0.
  - R_BURST: rvalid = 1, rid = latched id, rresp = OKAY, rlast = (cnt == len).
  - Counter advances on rvalid && rready; rdata stays stable while rready is low.
  - The last handshake returns the FSM to R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - awready = (state == W_IDLE).
  - W_DATA: wready = 1. Each wvalid beat writes the strobed bytes of word idx(cnt) and sets its valid bit.
  - The burst ends on wlast, or on cnt == len, whichever comes first. If the two disagree, proto_err is set.
  - W_RESP: bvalid = 1, bid = latched id, bresp = OKAY, held until bready.
- Simultaneous read beat and write beat to the same word: the read returns the pre-write value; the write commits at the clock edge.

## Timing
- Reset values: arready = 1, awready = 1, rvalid = 0, rlast = 0, wready = 0, bvalid = 0, proto_err = 0. rdata, rid, bid are 0.
- AR handshake at cycle t → first rvalid at t + 1 + RD_LATENCY.
- Last R handshake at cycle t → arready = 1 at t + 1.
- AW handshake at cycle t → wready = 1 at t + 1.
- Final W beat at cycle t → bvalid at t + 1.
- B handshake at cycle t → awready at t + 1.
- Read and write paths never stall each other.
- rst mid-burst aborts both FSMs immediately to IDLE and clears all valid bits.
- Counters are 4 bits; len = 15 gives 16 beats with no overflow.

## Configuration
- AXI_SLAVE_RAND_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every cycle. rvalid in R_BURST and wready in W_DATA are forced to 0 on cycles where lfsr[1:0] == 2'b00. rlast and rdata stay stable through a stall.
- Not defined: no LFSR and no stalls; timing is exactly as stated above.

## Test plan
- Reset, then AR addr 0x100, len 3, INCR, RD_LATENCY 2 → AR handshake at cycle 0; rvalid first at cycle 3; rdata 0x100, 0x104, 0x108, 0x10C; rlast on the 4th beat.
- AW 0x40 len 1 id 5, W beats 0xDEADBEEF (strb F) and 0x12345678 (strb 3, wlast) → B with bid 5 one cycle after the final beat. A subsequent read of 0x40 len 1 returns 0xDEADBEEF, 0x00005678 (unwritten bytes 0).
- WRAP read addr 0x18 len 3 → data 0x18, 0x1C, 0x10, 0x14; proto_err stays 0.
- W with wlast asserted on beat 1 of an awlen = 3 burst → proto_err = 1, bvalid asserted, FSM back to W_IDLE after bready.
- Concurrent AR 0x200 and AW 0x200, with the write beat coinciding with the read beat → rdata = 0x200 (old value); a re-read returns the new data.
- Assert rst during beat 2 of a read burst → rvalid = 0 and arready = 1 the same cycle; proto_err = 0.
